// File: rtl/xeng_sched.sv
// X-engine window scheduler: gates W-word reads from the source FIFO and emits sync/valid aligned to FIFO data.
// Define XENG_SCHED_STATS_EN to build the window counter and sticky overflow flag.
module xeng_sched #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS              = 8,
  parameter int MCNT_WIDTH          = 48,
  parameter int FILL_WIDTH          = 16,
  parameter int FIFO_DEPTH          = 4096,
  parameter int RD_LATENCY          = 2,
  parameter int GAP_CYCLES          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  stop,
  input  logic [FILL_WIDTH-1:0] fifo_fill,
  input  logic [MCNT_WIDTH-1:0] fifo_mcnt,
  output logic                  fifo_rd,
  output logic                  xeng_sync,
  output logic                  xeng_vld,
  output logic [MCNT_WIDTH-1:0] xeng_mcnt,
  output logic                  busy,
  output logic [31:0]           win_count,
  output logic                  overflow
);

  localparam int W         = N_ANTS << SERIAL_ACC_LEN_BITS;
  localparam int RUN_CNT_W = $clog2(W + 1);
  localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(W - 1);
  localparam logic [7:0]  GAP_LAST     = 8'(GAP_CYCLES - 1);
  localparam logic [31:0] W_U          = 32'(W);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_DATA,
    RUN,
    GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [MCNT_WIDTH-1:0]  mcnt_q, mcnt_d;
  logic [RD_LATENCY-1:0]  vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0]  sync_pipe_q, sync_pipe_d;
  logic                   sync_src;
  logic                   fill_ok;
  logic                   run_last;

  assign fill_ok  = 32'(fifo_fill) >= W_U;
  assign run_last = (state_q == RUN) && (run_cnt_q == RUN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      mcnt_q      <= '0;
      vld_pipe_q  <= '0;
      sync_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      mcnt_q      <= mcnt_d;
      vld_pipe_q  <= vld_pipe_d;
      sync_pipe_q <= sync_pipe_d;
    end
  end

  // stop never cuts a window short; it is only honoured while waiting for data or at the end of the gap
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    mcnt_d    = mcnt_q;
    unique case (state_q)
      IDLE: begin
        if (arm && !stop) state_d = SYNC;
      end
      SYNC: begin
        state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (stop) begin
          state_d = IDLE;
        end else if (fill_ok) begin
          state_d   = RUN;
          run_cnt_d = '0;
          mcnt_d    = fifo_mcnt;
        end
      end
      RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          if (GAP_CYCLES == 0) begin
            state_d = stop ? IDLE : WAIT_DATA;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end else begin
          run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = stop ? IDLE : WAIT_DATA;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd  = (state_q == RUN);
    sync_src = (state_q == SYNC);
  end

  // Matching delay lines keep sync and valid aligned with the data the FIFO returns
  always_comb begin
    vld_pipe_d     = '0;
    sync_pipe_d    = '0;
    vld_pipe_d[0]  = fifo_rd;
    sync_pipe_d[0] = sync_src;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      sync_pipe_d[i] = sync_pipe_q[i-1];
    end
  end

  assign xeng_vld  = vld_pipe_q[RD_LATENCY-1];
  assign xeng_sync = sync_pipe_q[RD_LATENCY-1];
  assign xeng_mcnt = mcnt_q;
  assign busy      = (state_q != IDLE) || (|vld_pipe_q) || (|sync_pipe_q);

`ifdef XENG_SCHED_STATS_EN
  localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);

  logic [31:0] win_count_q, win_count_d;
  logic        overflow_q, overflow_d;

  always_comb begin
    win_count_d = win_count_q;
    if (run_last) win_count_d = win_count_q + 32'd1;
    overflow_d = overflow_q || (32'(fifo_fill) >= DEPTH_U);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      win_count_q <= win_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign win_count = win_count_q;
  assign overflow  = overflow_q;
`else
  assign win_count = '0;
  assign overflow  = 1'b0;
`endif

endmodule
